// File: rtl/qspi_arb.sv
// Line-fill/writeback arbiter: NCH cache requesters share one qspi controller.
// Grants one channel at a time, latches its context and routes nibble strobes back to it.
module qspi_arb #(
   parameter int NCH         = 2,
   parameter int PA          = 22,
   parameter int LINE_LENGTH = 4,
   parameter int RR          = 1,
   parameter int TIMEOUT     = 255,
   localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_write,
   input  logic [NCH-1:0]    ch_mem,
   input  logic [NCH*TW-1:0] ch_tag,
   output logic [NCH-1:0]    ch_grant,
   output logic [NCH-1:0]    ch_done,
   output logic [NCH-1:0]    ch_wstrobe,
   output logic [NCH-1:0]    ch_rstrobe,
   output logic              q_req,
   output logic              q_write,
   output logic              q_mem,
   output logic [TW-1:0]     q_tag,
   input  logic              q_wstrobe,
   input  logic              q_rstrobe,
   input  logic              q_done,
   output logic              q_abort,
   output logic              timeout
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE} state_t;

   state_t        state;
   logic [IW-1:0] gidx;
   logic [IW-1:0] ptr;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          wd_fire;

   // Descending scan so the candidate closest after the pointer (or lowest index) is written last.
   always_comb begin
      win_idx = '0;
      idx     = '0;
      if (RR != 0) begin
         for (int i = NCH; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % NCH);
            if (ch_req[idx]) win_idx = idx;
         end
      end else begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_req[i]) win_idx = IW'(i);
         end
      end
   end

   always_comb begin
      cnt_nxt = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
      wd_fire = (TIMEOUT != 0) && (cnt_nxt == CW'(TIMEOUT)) && !q_done;
   end

   assign ch_wstrobe = (state == BUSY && q_wstrobe) ? ch_grant : '0;
   assign ch_rstrobe = (state == BUSY && q_rstrobe) ? ch_grant : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ch_grant <= '0;
         ch_done  <= '0;
         q_req    <= 1'b0;
         q_write  <= 1'b0;
         q_mem    <= 1'b0;
         q_tag    <= '0;
         q_abort  <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= IW'(NCH - 1);
         gidx     <= '0;
         cnt      <= '0;
      end else begin
         ch_done <= '0;
         q_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (|ch_req) begin
                  gidx  <= win_idx;
                  state <= GRANT;
               end
            end
            GRANT: begin
               q_write  <= ch_write[gidx];
               q_mem    <= ch_mem[gidx];
               q_tag    <= ch_tag[gidx*TW +: TW];
               ch_grant <= NCH'(1) << gidx;
               cnt      <= '0;
               q_req    <= 1'b1;
               state    <= BUSY;
            end
            BUSY: begin
               cnt <= cnt_nxt;
               // q_done takes precedence over a watchdog expiry in the same cycle.
               if (q_done) begin
                  q_req   <= 1'b0;
                  ch_done <= ch_grant;
                  state   <= DONE;
               end else if (wd_fire) begin
                  q_req   <= 1'b0;
                  q_abort <= 1'b1;
                  timeout <= 1'b1;
                  ch_done <= ch_grant;
                  state   <= DONE;
               end
            end
            DONE: begin
               ptr      <= gidx;
               ch_grant <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
